// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register-file write-port logic.
// Holds the register-file geometry and the write-arbiter state encoding.
// This file has no ports.
package cpu_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // Highest register address; the zero-fill ends after writing it.
  localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NUM_REGS - 1);

  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-input round-robin arbiter.
// The grant is combinational. A last-grant register sets the starting point
// of the next scan, which begins one index past the previous winner.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (last resets to N-1)
//   en         : when low, no grant is issued
//   load       : record the current winner as the new last grant
//   req[N]     : request vector
//   gnt[N]     : one-hot grant, all-zero when nothing is requested or en=0
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW:0]   cand;
  logic          found;

  // cand stays below 2N, so a single conditional subtract wraps it modulo N.
  always_comb begin
    gnt   = '0;
    win   = last;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
    if (en && found) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (load && en && found) begin
      last <= win;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owner of the register file's single write port.
// After reset, the block zero-fills r1..r31. It then shares the port among N
// write-back requesters in round-robin order. All register-file signals come
// straight from flops.
//
//   state    | meaning
//   ARB_INIT | zero-fill in progress: one write per cycle, r1..r31, no grants
//   ARB_RUN  | normal operation: round-robin grant, one write per accept
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid[N]        : requester i holds a write
//   req_rw[5N]          : destination of requester i at [5i+4:5i]
//   req_din[32N]        : data of requester i at [32i+31:32i]
//   req_ready[N]        : one-hot grant (combinational)
//   rf_we/rf_rw/rf_din  : register-file write port (registered)
//   init_done           : zero-fill complete
//   pend_valid/pend_rw  : in-flight write, for read-side forwarding
module rf_write_arbiter
  import cpu_pkg::*;
#(
  parameter int N       = 3,
  parameter bit INIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [REG_AW*N-1:0] req_rw,
  input  logic [DATA_W*N-1:0] req_din,
  output logic [N-1:0]        req_ready,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_rw,
  output logic [DATA_W-1:0]   rf_din,
  output logic                init_done,
  output logic                pend_valid,
  output logic [REG_AW-1:0]   pend_rw
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("rf_write_arbiter: N must be in 2..8");
  end

  arb_state_t        state, nxt_state;
  logic [REG_AW-1:0] cnt, nxt_cnt;
  logic              nxt_we, nxt_done;
  logic [REG_AW-1:0] nxt_rw, sel_rw;
  logic [DATA_W-1:0] nxt_din, sel_din;
  logic              accept;

  // Grants only count in RUN. Valid must be held until it is accepted,
  // so every grant is an accept.
  rr_arbiter #(.N(N)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ARB_RUN),
    .load  (accept),
    .req   (req_valid),
    .gnt   (req_ready)
  );

  assign accept = |req_ready;

  always_comb begin
    sel_rw  = '0;
    sel_din = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        sel_rw  = req_rw[i*REG_AW +: REG_AW];
        sel_din = req_din[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_we    = 1'b0;
    nxt_rw    = rf_rw;
    nxt_din   = rf_din;
    nxt_done  = init_done;
    case (state)
      ARB_INIT: begin
        nxt_we  = 1'b1;
        nxt_rw  = cnt;
        nxt_din = '0;
        nxt_cnt = cnt + REG_AW'(1);
        if (cnt == LAST_REG) begin
          nxt_state = ARB_RUN;
          nxt_done  = 1'b1;
        end
      end
      ARB_RUN: begin
        // Without a fill, RUN itself means the register file is usable.
        nxt_done = 1'b1;
        if (accept) begin
          nxt_rw  = sel_rw;
          nxt_din = sel_din;
          // A write to r0 is accepted but never reaches the register file.
          nxt_we  = (sel_rw != '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_EN ? ARB_INIT : ARB_RUN;
      cnt       <= REG_AW'(1);
      rf_we     <= 1'b0;
      rf_rw     <= '0;
      rf_din    <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      rf_we     <= nxt_we;
      rf_rw     <= nxt_rw;
      rf_din    <= nxt_din;
      init_done <= nxt_done;
    end
  end

  assign pend_valid = rf_we;
  assign pend_rw    = rf_rw;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter.
// u_a uses INIT_EN=1 and u_b uses INIT_EN=0. Both instances share the clock
// and the reset.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;

  logic [2:0]  a_valid, a_ready;
  logic [14:0] a_rw;
  logic [95:0] a_din;
  logic        a_we, a_done, a_pv;
  logic [4:0]  a_rwo, a_prw;
  logic [31:0] a_dino;

  logic [2:0]  b_valid, b_ready;
  logic [14:0] b_rw;
  logic [95:0] b_din;
  logic        b_we, b_done, b_pv;
  logic [4:0]  b_rwo, b_prw;
  logic [31:0] b_dino;

  int n_checks;
  int n_fail;

  rf_write_arbiter #(.N(3), .INIT_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_valid), .req_rw(a_rw), .req_din(a_din), .req_ready(a_ready),
    .rf_we(a_we), .rf_rw(a_rwo), .rf_din(a_dino), .init_done(a_done),
    .pend_valid(a_pv), .pend_rw(a_prw)
  );

  rf_write_arbiter #(.N(3), .INIT_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_rw(b_rw), .req_din(b_din), .req_ready(b_ready),
    .rf_we(b_we), .rf_rw(b_rwo), .rf_din(b_dino), .init_done(b_done),
    .pend_valid(b_pv), .pend_rw(b_prw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  // Starting from last=0, the scan order is 1,2,0,... Requester 1 drops out
  // after its second accept and requester 2 after its second accept.
  logic [2:0] rr_valid [6];
  logic [2:0] rr_gnt   [6];
  logic [4:0] rr_rw    [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    a_valid = '0; a_rw = '0; a_din = '0;
    b_valid = '0; b_rw = '0; b_din = '0;
    rr_valid = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b001};
    rr_gnt   = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    rr_rw    = '{5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd1};

    repeat (2) @(negedge clk);
    chk("reset_we", a_we, 1'b0);
    chk("reset_rw", a_rwo, 5'd0);
    chk("reset_din", a_dino, 32'd0);
    chk("reset_done", a_done, 1'b0);
    chk("reset_ready", a_ready, 3'b000);
    chk("reset_pend", a_pv, 1'b0);
    chk("reset_b_we", b_we, 1'b0);

    // Requester 0 is presented during the fill and held until it is accepted.
    a_rw[4:0] = 5'd5;  a_din[31:0] = 32'hDEADBEEF;  a_valid = 3'b001;
    b_rw[14:10] = 5'd7; b_din[95:64] = 32'hCAFEF00D; b_valid = 3'b100;
    rst_n = 1'b1;
    #1;
    chk("b_ready_immediate", b_ready, 3'b100);
    chk("a_ready_init", a_ready, 3'b000);

    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("fill_we", a_we, 1'b1);
      chk("fill_rw", a_rwo, i[4:0]);
      chk("fill_din", a_dino, 32'd0);
      chk("fill_ready", a_ready, (i < 31) ? 3'b000 : 3'b001);
      chk("fill_done", a_done, (i == 31) ? 1'b1 : 1'b0);
      if (i == 1) begin
        chk("b_first_we", b_we, 1'b1);
        chk("b_first_rw", b_rwo, 5'd7);
        chk("b_first_din", b_dino, 32'hCAFEF00D);
        b_valid = 3'b000;
      end
      if (i == 2) chk("b_we_drop", b_we, 1'b0);
    end

    @(negedge clk);
    chk("req0_we", a_we, 1'b1);
    chk("req0_rw", a_rwo, 5'd5);
    chk("req0_din", a_dino, 32'hDEADBEEF);
    chk("req0_pend_valid", a_pv, 1'b1);
    chk("req0_pend_rw", a_prw, 5'd5);
    a_valid = 3'b000;
    #1;
    chk("idle_ready", a_ready, 3'b000);
    @(negedge clk);
    chk("idle_we", a_we, 1'b0);
    chk("idle_pend", a_pv, 1'b0);
    chk("idle_rw_hold", a_rwo, 5'd5);
    chk("idle_din_hold", a_dino, 32'hDEADBEEF);

    a_rw  = {5'd3, 5'd2, 5'd1};
    a_din = {32'hA3, 32'hA2, 32'hA1};
    for (int s = 0; s < 6; s++) begin
      if (s > 0) begin
        chk("rr_we", a_we, 1'b1);
        chk("rr_rw", a_rwo, rr_rw[s-1]);
      end
      a_valid = rr_valid[s];
      #1;
      chk("rr_grant", a_ready, rr_gnt[s]);
      @(negedge clk);
    end
    chk("rr_last_we", a_we, 1'b1);
    chk("rr_last_rw", a_rwo, 5'd1);
    chk("rr_last_din", a_dino, 32'hA1);
    a_valid = 3'b000;
    @(negedge clk);
    chk("rr_after_we", a_we, 1'b0);

    // Write to r0: accepted and dropped. last=0, so requester 1 is scanned first.
    a_rw[9:5] = 5'd0; a_din[63:32] = 32'h1234; a_valid = 3'b010;
    #1;
    chk("r0_ready", a_ready, 3'b010);
    @(negedge clk);
    chk("r0_we", a_we, 1'b0);
    chk("r0_pend", a_pv, 1'b0);
    chk("r0_rw", a_rwo, 5'd0);
    chk("r0_din", a_dino, 32'h1234);
    a_valid = 3'b000;

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_run_we", a_we, 1'b0);
    chk("rst_run_din", a_dino, 32'd0);
    chk("rst_run_done", a_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("refill_rw", a_rwo, i[4:0]);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_fill_we", a_we, 1'b0);
    chk("rst_fill_rw", a_rwo, 5'd0);
    chk("rst_fill_done", a_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("restart_we", a_we, 1'b1);
      chk("restart_rw", a_rwo, i[4:0]);
      chk("restart_done", a_done, (i == 31) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk("restart_idle_we", a_we, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
